// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: issues sequential fetches to a variable-latency memory and buffers
// returned words in an in-order prefetch queue; redirects flush the queue and drop stale responses.
module fetch_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc4
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {FETCH, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [XLEN-1:0] inst_q [DEPTH];
  logic [XLEN-1:0] pc4_q  [DEPTH];

  logic credit, issue, pop, push;

  // Queue slots already reserved by in-flight requests count against the credit.
  assign credit    = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH);
  assign imem_req  = !rst && !redirect_valid && credit;
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;

  assign out_valid = (count_q != '0);
  assign out_inst  = out_valid ? inst_q[head_q] : '0;
  assign out_pc4   = out_valid ? pc4_q[head_q] : fetch_pc_q + XLEN'(4);
  assign pop       = out_valid && out_ready;

  assign push      = imem_rvalid && !redirect_valid && (state_q == FETCH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid);

    if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = inflight_d;
      state_d    = (inflight_d != '0) ? FLUSH : FETCH;
    end else begin
      if (push) begin
        tail_d    = tail_q + PW'(1);
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      // Every response seen while flushing belongs to a request issued before the redirect.
      if ((state_q == FLUSH) && imem_rvalid) begin
        drop_d = drop_q - CW'(1);
        if (drop_d == '0) begin
          state_d = FETCH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_q[tail_q] <= imem_rdata;
      pc4_q[tail_q]  <= resp_pc_q + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit: a queue-based memory and prefetch model predicts
// every cycle's outputs; directed phases pin the model with literal expectations.
module tb_fetch_prefetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst, imem_req, imem_gnt, imem_rvalid, redirect_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_inst, out_pc4;

  logic        rst2, req2, gnt2, rvalid2, redir2, ov2, ordy2;
  logic [31:0] addr2, rdata2, rpc2, oinst2, opc4_2;

  fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc4(out_pc4));

  fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC2)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .redirect_valid(redir2),
    .redirect_pc(rpc2), .out_valid(ov2), .out_ready(ordy2),
    .out_inst(oinst2), .out_pc4(opc4_2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {logic [31:0] addr; int epoch; int due;} req_t;
  typedef struct {logic [31:0] inst; logic [31:0] pc4;} ent_t;

  req_t        pend[$];
  ent_t        mq[$];
  logic [31:0] fpc;
  int          epoch, cyc, last_due;
  int          errors, checks;
  int          gnt_pct, rdy_pct, redir_pct, rst_pct, lat_min, lat_max;
  int          trig_mode;
  logic [31:0] trig_pc;
  bit          fired, prev_rst, hold_rst;
  logic [31:0] hs_pc4[$];
  int          hs_cyc[$];
  logic [31:0] a2[$], p2_pc4[$], p2_inst[$];
  int          n0, r0;
  bit          pv;
  logic [31:0] pa;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] hs_at(input int i);
    return (i >= 0 && i < hs_pc4.size()) ? hs_pc4[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fire();
    redirect_valid = 1'b1;
    redirect_pc    = trig_pc;
    fired          = 1'b1;
    trig_mode      = 0;
  endtask

  // One clock cycle: drive inputs just after the edge, check outputs, advance the model.
  task automatic cycle();
    logic exp_req, iss, pp, stl, frs;
    ent_t e;
    req_t p;
    int   d;
    rst            = hold_rst || ($urandom_range(999) < rst_pct);
    imem_gnt       = ($urandom_range(99) < gnt_pct);
    out_ready      = ($urandom_range(99) < rdy_pct);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = img(pend[0].addr);
    end
    if (!rst) begin
      stl = 1'b0;
      frs = 1'b0;
      foreach (pend[i]) begin
        if (pend[i].epoch != epoch) stl = 1'b1;
        else frs = 1'b1;
      end
      case (trig_mode)
        1: fire();
        2: if (pend.size() == 2) fire();
        3: if (mq.size() > 0 && imem_rvalid) begin out_ready = 1'b1; fire(); end
        4: if (stl && frs) fire();
        default: if ($urandom_range(99) < redir_pct) begin
          redirect_valid = 1'b1;
          redirect_pc    = $urandom & 32'h0000_0FFC;
        end
      endcase
    end
    #1;
    exp_req = !rst && !redirect_valid && (mq.size() + pend.size() < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    chk("imem_addr", imem_addr, fpc);
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("out_inst", out_inst, mq[0].inst);
      chk("out_pc4", out_pc4, mq[0].pc4);
    end
    if (prev_rst) begin
      chk("reset_inst", out_inst, 32'h0);
      chk("reset_pc4", out_pc4, 32'h4);
    end
    iss = imem_req && imem_gnt;
    pp  = out_valid && out_ready;
    if (rst) begin
      pend.delete();
      mq.delete();
      fpc      = 32'h0;
      epoch++;
      last_due = 0;
    end else begin
      if (pp && mq.size() > 0) begin
        e = mq.pop_front();
        hs_pc4.push_back(out_pc4);
        hs_cyc.push_back(cyc);
      end
      if (imem_rvalid) begin
        p = pend.pop_front();
        if (p.epoch == epoch && !redirect_valid) mq.push_back('{img(p.addr), p.addr + 32'd4});
      end
      if (redirect_valid) begin
        mq.delete();
        epoch++;
        fpc = redirect_pc;
      end
      if (iss) begin
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d <= last_due) d = last_due + 1;
        pend.push_back('{fpc, epoch, d});
        last_due = d;
        fpc      = fpc + 32'd4;
      end
    end
    prev_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; epoch = 0; last_due = 0; fpc = 32'h0;
    gnt_pct = 100; rdy_pct = 100; redir_pct = 0; rst_pct = 0; lat_min = 1; lat_max = 1;
    trig_mode = 0; trig_pc = '0; fired = 1'b0; hold_rst = 1'b1; prev_rst = 1'b1;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    rst2 = 1'b1; gnt2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0; redir2 = 1'b0; rpc2 = '0; ordy2 = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) cycle();

    // Sustained fetch from reset, latency 1
    hold_rst = 1'b0;
    hs_pc4.delete();
    hs_cyc.delete();
    r0 = cyc;
    repeat (8) cycle();
    chk("t1_pc4_0", hs_at(0), 32'd4);
    chk("t1_pc4_1", hs_at(1), 32'd8);
    chk("t1_pc4_2", hs_at(2), 32'd12);
    chk("t1_pc4_3", hs_at(3), 32'd16);
    chk("t1_first_cycle", 32'(hs_cyc.size() > 0 ? hs_cyc[0] : -1), 32'(r0 + 2));
    chk("t1_back_to_back", 32'(hs_cyc.size() > 3 ? hs_cyc[3] - hs_cyc[0] : -1), 32'd3);

    // Decode stall: queue fills to DEPTH, then drains exactly DEPTH entries
    rdy_pct = 0;
    repeat (10) cycle();
    chk("t2_req_low", 32'(imem_req), 32'd0);
    chk("t2_full", 32'(out_valid), 32'd1);
    n0 = hs_pc4.size();
    gnt_pct = 0;
    rdy_pct = 100;
    repeat (6) cycle();
    chk("t2_drained", 32'(hs_pc4.size() - n0), 32'd4);
    chk("t2_first", hs_at(n0), hs_at(n0 - 1) + 32'd4);
    chk("t2_last", hs_at(n0 + 3), hs_at(n0) + 32'd12);
    chk("t2_empty", 32'(out_valid), 32'd0);

    // Redirect with two requests in flight, latency 3
    gnt_pct = 100; lat_min = 3; lat_max = 3;
    trig_pc = 32'h40; fired = 1'b0; trig_mode = 2;
    for (int i = 0; i < 10 && !fired; i++) cycle();
    chk("t3_fired", 32'(fired), 32'd1);
    n0 = hs_pc4.size();
    repeat (12) cycle();
    chk("t3_first_pc4", hs_at(n0), 32'h44);

    // Redirect coinciding with an output handshake and a response
    lat_min = 1; lat_max = 1;
    repeat (6) cycle();
    trig_pc = 32'h200; fired = 1'b0; trig_mode = 3;
    for (int i = 0; i < 20 && !fired; i++) cycle();
    chk("t4_fired", 32'(fired), 32'd1);
    chk("t4_empty", 32'(out_valid), 32'd0);
    n0 = hs_pc4.size();
    repeat (8) cycle();
    chk("t4_next_pc4", hs_at(n0), 32'h204);

    // Second redirect while still flushing the first
    gnt_pct = 0;
    repeat (8) cycle();
    gnt_pct = 100; lat_min = 5; lat_max = 5;
    trig_pc = 32'h40; fired = 1'b0; trig_mode = 2;
    for (int i = 0; i < 10 && !fired; i++) cycle();
    chk("t5_fired_a", 32'(fired), 32'd1);
    n0 = hs_pc4.size();
    trig_pc = 32'h80; fired = 1'b0; trig_mode = 4;
    for (int i = 0; i < 10 && !fired; i++) cycle();
    chk("t5_fired_b", 32'(fired), 32'd1);
    repeat (16) cycle();
    chk("t5_first_pc4", hs_at(n0), 32'h84);

    // Random traffic with redirects and occasional resets
    trig_mode = 0; gnt_pct = 70; rdy_pct = 70; redir_pct = 4; rst_pct = 3;
    lat_min = 1; lat_max = 4;
    repeat (3000) cycle();
    rst_pct = 0;
    hold_rst = 1'b1;
    cycle();

    // Address wrap from a high reset PC, then reset mid-stream
    rst2 = 1'b0;
    pv = 1'b0;
    pa = '0;
    for (int i = 0; i < 6; i++) begin
      rvalid2 = pv;
      rdata2  = img(pa);
      #1;
      if (ov2) begin
        p2_pc4.push_back(opc4_2);
        p2_inst.push_back(oinst2);
      end
      if (req2) a2.push_back(addr2);
      pv = req2;
      pa = addr2;
      @(posedge clk);
      #1;
    end
    chk("t6_addr0", qget(a2, 0), 32'hFFFF_FFF8);
    chk("t6_addr1", qget(a2, 1), 32'hFFFF_FFFC);
    chk("t6_addr2", qget(a2, 2), 32'h0000_0000);
    chk("t6_pc4_0", qget(p2_pc4, 0), 32'hFFFF_FFFC);
    chk("t6_pc4_1", qget(p2_pc4, 1), 32'h0000_0000);
    chk("t6_pc4_2", qget(p2_pc4, 2), 32'h0000_0004);
    chk("t6_inst0", qget(p2_inst, 0), img(32'hFFFF_FFF8));
    chk("t6_valid_before_rst", 32'(ov2), 32'd1);
    rst2    = 1'b1;
    rvalid2 = 1'b0;
    #1;
    chk("t6_req_in_rst", 32'(req2), 32'd0);
    @(posedge clk);
    #1;
    chk("t6_valid_after_rst", 32'(ov2), 32'd0);
    chk("t6_addr_after_rst", addr2, RPC2);
    chk("t6_inst_after_rst", oinst2, 32'h0);
    chk("t6_pc4_after_rst", opc4_2, RPC2 + 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
